icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_WIDTH, default 6, number of index bits (2^INDEX_WIDTH one-word lines).
REQ-002 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 Parameter INST_WIDTH, default 32, instruction and line width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-low.
REQ-006 rdy_in  input  1  global enable; low freezes all state and outputs.
REQ-007 flush  input  1  pipeline flush from ROB; aborts any in-progress access.
REQ-008 if2ic_req  input  1  fetch request from ifetch, level-held.
REQ-009 if2ic_addr  input  ADDR_WIDTH  fetch byte address.
REQ-010 ic2if_rdy  output  1  one-cycle pulse; instruction valid.
REQ-011 ic2if_inst  output  INST_WIDTH  returned instruction.
REQ-012 ic2mem_req  output  1  miss request to memory arbiter, held until served.
REQ-013 ic2mem_addr  output  ADDR_WIDTH  word-aligned miss address.
REQ-014 mem2ic_rdy  input  1  one-cycle pulse; arbiter word valid.
REQ-015 mem2ic_data  input  INST_WIDTH  word returned by arbiter.

Function
REQ-016 Direct-mapped; index = addr[INDEX_WIDTH+1:2], tag = addr[ADDR_WIDTH-1:INDEX_WIDTH+2]; addr[1:0] ignored.
REQ-017 Each line holds valid bit, tag, one INST_WIDTH word.
REQ-018 FSM states IDLE, MISS, RESP; reset state IDLE.
REQ-019 IDLE, if2ic_req=1, hit: next edge load ic2if_inst with line data, ic2if_rdy=1, go RESP (1-cycle hit latency).
REQ-020 IDLE, if2ic_req=1, miss: next edge ic2mem_req=1, ic2mem_addr={addr[ADDR_WIDTH-1:2],2'b00}, latch addr, go MISS.
REQ-021 IDLE, if2ic_req=0: remain IDLE, outputs rdy/mem_req low.
REQ-022 MISS: hold ic2mem_req and ic2mem_addr stable until mem2ic_rdy=1.
REQ-023 MISS, mem2ic_rdy=1: next edge write line (valid=1, latched tag, data), ic2if_inst=mem2ic_data, ic2if_rdy=1, ic2mem_req=0, go RESP.
REQ-024 RESP: ic2if_rdy=0, request inputs not evaluated this cycle; next edge go IDLE (avoids re-serving the stale address while ifetch advances PC).
REQ-025 ic2if_rdy is high for exactly one cycle per served request; never high in consecutive cycles.
REQ-026 Sustained hit throughput: one instruction per two cycles.
REQ-027 flush=1 (any state, priority over all else): next edge ic2if_rdy=0, ic2mem_req=0, go IDLE; no instruction delivered.
REQ-028 flush=1 with mem2ic_rdy=1 same cycle in MISS: line is still filled (data valid) but not forwarded.
REQ-029 Deasserting ic2mem_req cancels the arbiter transaction; mem2ic_rdy outside MISS is ignored.
REQ-030 rdy_in=0: no state, array or output register changes; flush and requests that cycle are ignored.
REQ-031 No invalidate port; lines are never evicted except by replacement on fill to the same index.
REQ-032 ic2if_inst holds last delivered value when ic2if_rdy=0.

Reset
REQ-033 rst_in low asynchronously: state IDLE, all valid bits 0, ic2if_rdy=0, ic2if_inst=0, ic2mem_req=0, ic2mem_addr=0.
REQ-034 Reset mid-MISS drops ic2mem_req immediately (asynchronous), no fill occurs.
REQ-035 After rst_in rises, first access to any address is a miss.

Verification
REQ-036 Cold miss: req addr 0x0000_1004, arbiter returns 0x0000_0513 after 5 cycles -> ic2mem_addr 0x1004 held 5 cycles, ic2if_rdy pulse with inst 0x0000_0513 one cycle after mem2ic_rdy.
REQ-037 Hit: re-request 0x1006 -> no ic2mem_req, ic2if_rdy one cycle later with 0x0000_0513, then one idle cycle.
REQ-038 Conflict: fill 0x1004 then 0x1104 (same index, INDEX_WIDTH=6) -> second misses; subsequent 0x1004 misses again.
REQ-039 Flush in MISS: flush during wait, arbiter rdy 2 cycles later -> ic2mem_req drops next edge, no ic2if_rdy, line not written.
REQ-040 Flush coincident with mem2ic_rdy -> no ic2if_rdy; immediate re-request of same address hits.
REQ-041 rdy_in low 3 cycles during MISS with mem2ic_rdy pulse ignored -> state, ic2mem_req unchanged; completion only on a later mem2ic_rdy with rdy_in high.

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-line instruction cache with a single
// outstanding miss to the memory arbiter and a one-cycle hit latency.
module icache #(
  parameter int INDEX_WIDTH = 6,
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  if2ic_req,
  input  logic [ADDR_WIDTH-1:0] if2ic_addr,
  output logic                  ic2if_rdy,
  output logic [INST_WIDTH-1:0] ic2if_inst,
  output logic                  ic2mem_req,
  output logic [ADDR_WIDTH-1:0] ic2mem_addr,
  input  logic                  mem2ic_rdy,
  input  logic [INST_WIDTH-1:0] mem2ic_data
);
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;
  state_t state, state_d;
  logic [LINES-1:0]       valid;
  logic [TAG_WIDTH-1:0]   tags  [LINES];
  logic [INST_WIDTH-1:0]  lines [LINES];
  logic [INDEX_WIDTH-1:0] req_idx, fill_idx;
  logic [TAG_WIDTH-1:0]   req_tag, fill_tag;
  logic                   hit, fill, rdy_d, mem_req_d;
  logic [INST_WIDTH-1:0]  inst_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_d;
  assign req_idx  = if2ic_addr[INDEX_WIDTH+1:2];
  assign req_tag  = if2ic_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  // The held miss address doubles as the latched fill address.
  assign fill_idx = ic2mem_addr[INDEX_WIDTH+1:2];
  assign fill_tag = ic2mem_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign hit      = valid[req_idx] && tags[req_idx] == req_tag;
  always_comb begin
    state_d    = state;
    rdy_d      = 1'b0;
    inst_d     = ic2if_inst;
    mem_req_d  = ic2mem_req;
    mem_addr_d = ic2mem_addr;
    fill       = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      fill      = state == MISS && mem2ic_rdy;
    end else begin
      case (state)
        IDLE: if (if2ic_req) begin
          state_d    = hit ? RESP : MISS;
          rdy_d      = hit;
          inst_d     = hit ? lines[req_idx] : ic2if_inst;
          mem_req_d  = !hit;
          mem_addr_d = hit ? ic2mem_addr : if2ic_addr & ~ADDR_WIDTH'(3);
        end
        MISS: if (mem2ic_rdy) begin
          state_d   = RESP;
          rdy_d     = 1'b1;
          inst_d    = mem2ic_data;
          mem_req_d = 1'b0;
          fill      = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      valid       <= '0;
      ic2if_rdy   <= 1'b0;
      ic2if_inst  <= '0;
      ic2mem_req  <= 1'b0;
      ic2mem_addr <= '0;
    end else if (rdy_in) begin
      state       <= state_d;
      ic2if_rdy   <= rdy_d;
      ic2if_inst  <= inst_d;
      ic2mem_req  <= mem_req_d;
      ic2mem_addr <= mem_addr_d;
      if (fill) valid[fill_idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rdy_in && fill) begin
      tags[fill_idx]  <= fill_tag;
      lines[fill_idx] <= mem2ic_data;
    end
  end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed vector table of fetches plus hand-written flush,
// stall and reset sequences for the icache.
module tb_icache;
  logic        clk = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, flush = 1'b0;
  logic        req = 1'b0, rdy, mem_req, mem_rdy = 1'b0;
  logic [31:0] addr = '0, inst, mem_addr, mem_data = '0;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] addr;
    int          dly;
    logic [31:0] data;
    logic        miss;
    logic [31:0] inst;
  } vec_t;
  vec_t vecs[10];
  icache dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .if2ic_req(req), .if2ic_addr(addr), .ic2if_rdy(rdy), .ic2if_inst(inst),
    .ic2mem_req(mem_req), .ic2mem_addr(mem_addr),
    .mem2ic_rdy(mem_rdy), .mem2ic_data(mem_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask
  // Drives one fetch; on an expected miss the arbiter answers after dly cycles.
  task automatic fetch(input logic [31:0] a, input int dly, input logic [31:0] d,
                       input logic m, input logic [31:0] e);
    req = 1'b1; addr = a;
    @(negedge clk);
    chk("miss_req", mem_req, m);
    if (m) begin
      chk("miss_addr", mem_addr, a & ~32'h3);
      chk("miss_nordy", rdy, 0);
      repeat (dly - 1) begin
        @(negedge clk);
        chk("miss_hold_req", mem_req, 1);
        chk("miss_hold_addr", mem_addr, a & ~32'h3);
      end
      mem_rdy = 1'b1; mem_data = d;
      @(negedge clk);
      mem_rdy = 1'b0;
      chk("fill_req_drop", mem_req, 0);
    end
    chk("rdy", rdy, 1);
    chk("inst", inst, e);
    @(negedge clk);
    chk("rdy_pulse", rdy, 0);
    chk("resp_noreq", mem_req, 0);
    chk("inst_hold", inst, e);
    req = 1'b0;
  endtask
  initial begin
    vecs[0] = '{32'h0000_1004, 5, 32'h0000_0513, 1'b1, 32'h0000_0513};
    vecs[1] = '{32'h0000_1006, 0, 32'h0,         1'b0, 32'h0000_0513};
    vecs[2] = '{32'h0000_1104, 2, 32'hAAAA_0001, 1'b1, 32'hAAAA_0001};
    vecs[3] = '{32'h0000_1104, 0, 32'h0,         1'b0, 32'hAAAA_0001};
    vecs[4] = '{32'h0000_1004, 1, 32'h0000_0513, 1'b1, 32'h0000_0513};
    vecs[5] = '{32'h0000_2008, 3, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[6] = '{32'h0000_2008, 0, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[7] = '{32'h0000_1007, 0, 32'h0,         1'b0, 32'h0000_0513};
    vecs[8] = '{32'hFFFF_FFFC, 1, 32'h1234_5678, 1'b1, 32'h1234_5678};
    vecs[9] = '{32'hFFFF_FFFE, 0, 32'h0,         1'b0, 32'h1234_5678};
    #1;
    chk("rst_rdy", rdy, 0);
    chk("rst_inst", inst, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(negedge clk); rst_in = 1'b1;
    @(negedge clk);
    chk("idle_rdy", rdy, 0);
    chk("idle_mem_req", mem_req, 0);
    for (int i = 0; i < 10; i++)
      fetch(vecs[i].addr, vecs[i].dly, vecs[i].data, vecs[i].miss, vecs[i].inst);
    // Flush while waiting: late arbiter word must not fill the line.
    req = 1'b1; addr = 32'h0000_3000;
    @(negedge clk);
    chk("fl_miss_req", mem_req, 1);
    flush = 1'b1; req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_req_drop", mem_req, 0);
    chk("fl_nordy", rdy, 0);
    @(negedge clk);
    mem_rdy = 1'b1; mem_data = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_rdy = 1'b0;
    chk("fl_late_nordy", rdy, 0);
    chk("fl_inst_hold", inst, 32'h1234_5678);
    fetch(32'h0000_3000, 2, 32'h3333_3333, 1'b1, 32'h3333_3333);
    // Flush coincident with the arbiter word: line filled, not forwarded.
    req = 1'b1; addr = 32'h0000_4010;
    @(negedge clk);
    chk("flc_miss_req", mem_req, 1);
    flush = 1'b1; req = 1'b0; mem_rdy = 1'b1; mem_data = 32'h4444_4444;
    @(negedge clk);
    flush = 1'b0; mem_rdy = 1'b0;
    chk("flc_nordy", rdy, 0);
    chk("flc_req_drop", mem_req, 0);
    fetch(32'h0000_4010, 0, 32'h0, 1'b0, 32'h4444_4444);
    // Stall during a miss: arbiter pulse and flush are both ignored.
    req = 1'b1; addr = 32'h0000_5020;
    @(negedge clk);
    chk("st_miss_req", mem_req, 1);
    rdy_in = 1'b0; mem_rdy = 1'b1; mem_data = 32'h9999_9999;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      @(negedge clk);
      chk("st_hold_req", mem_req, 1);
      chk("st_hold_addr", mem_addr, 32'h0000_5020);
      chk("st_nordy", rdy, 0);
    end
    rdy_in = 1'b1; mem_rdy = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("st_still_miss", mem_req, 1);
    chk("st_still_nordy", rdy, 0);
    mem_rdy = 1'b1; mem_data = 32'h5555_5555;
    @(negedge clk);
    mem_rdy = 1'b0;
    chk("st_rdy", rdy, 1);
    chk("st_inst", inst, 32'h5555_5555);
    @(negedge clk);
    req = 1'b0;
    chk("st_pulse", rdy, 0);
    fetch(32'h0000_5020, 0, 32'h0, 1'b0, 32'h5555_5555);
    // Asynchronous reset mid-miss, then everything misses again.
    req = 1'b1; addr = 32'h0000_6000;
    @(negedge clk);
    chk("ar_miss_req", mem_req, 1);
    #2 rst_in = 1'b0;
    #1;
    chk("ar_req_drop", mem_req, 0);
    chk("ar_inst", inst, 0);
    chk("ar_mem_addr", mem_addr, 0);
    req = 1'b0;
    @(negedge clk); rst_in = 1'b1;
    @(negedge clk);
    fetch(32'h0000_1004, 2, 32'h0000_0777, 1'b1, 32'h0000_0777);
    fetch(32'h0000_4010, 1, 32'h4545_4545, 1'b1, 32'h4545_4545);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
